// File: rtl/serie_pkg.sv
// serie_pkg -- shared definitions for the serial-to-parallel receiver.
//   serie_state_t         : receiver FSM states (PARITY only with SERIE_PARITY_EN)
//   SERIE_MSB_FIRST/LSB   : LeRi encodings
//   SERIE_WIDTH_MIN/MAX   : legal range of the WIDTH parameter
//   serie_parity_err()    : even-parity check over data bits plus parity bit
package serie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SERIE_PARITY_EN
    ,ST_PARITY = 2'd2
`endif
  } serie_state_t;

  localparam logic SERIE_MSB_FIRST = 1'b1;
  localparam logic SERIE_LSB_FIRST = 1'b0;

  localparam int SERIE_WIDTH_MIN = 2;
  localparam int SERIE_WIDTH_MAX = 16;

  // Data is zero-extended to the maximum width; zero bits do not change the XOR.
  function automatic logic serie_parity_err(input logic [SERIE_WIDTH_MAX-1:0] data,
                                            input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/serie_paralelo_receiver_if.sv
// serie_paralelo_receiver_if -- serial input strobes and parallel result bus.
//   Data_In, Ena, Start, LeRi : serial side, driven by the master
//   Data_Out, Valid, Busy, Abort (and Parity_Err with SERIE_PARITY_EN) : results
//   slave modport : receiver side;  master modport : bit source / consumer side
interface serie_paralelo_receiver_if #(
  parameter int WIDTH = 4
);
  logic             Data_In;
  logic             Ena;
  logic             Start;
  logic             LeRi;
  logic [WIDTH-1:0] Data_Out;
  logic             Valid;
  logic             Busy;
  logic             Abort;
`ifdef SERIE_PARITY_EN
  logic             Parity_Err;
`endif

  modport slave (
    input  Data_In, Ena, Start, LeRi,
    output Data_Out, Valid, Busy, Abort
`ifdef SERIE_PARITY_EN
    ,output Parity_Err
`endif
  );

  modport master (
    output Data_In, Ena, Start, LeRi,
    input  Data_Out, Valid, Busy, Abort
`ifdef SERIE_PARITY_EN
    ,input Parity_Err
`endif
  );
endinterface

// File: rtl/serie_shift_core.sv
// serie_shift_core -- WIDTH-bit bidirectional shift register.
//   Clk, Rst (async active-low) : clock and reset
//   shift_en : shift Data_In into the register this edge
//   clear    : zero the register; together with shift_en the new bit lands
//              in an otherwise empty register (first bit of a frame)
//   dir      : 1 = shift left (MSB first), 0 = shift right (LSB first)
//   Data_In  : serial bit;  q : parallel register contents
module serie_shift_core import serie_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             dir,
  input  logic             Data_In,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] base_s;

  // Starting value for the shift: empty when a frame is being (re)started.
  always_comb begin
    if (clear) begin
      base_s = {WIDTH{1'b0}};
    end else begin
      base_s = shreg_r;
    end
  end

  // Shift register update.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (shift_en) begin
      if (dir == SERIE_MSB_FIRST) begin
        shreg_r <= {base_s[WIDTH-2:0], Data_In};
      end else begin
        shreg_r <= {Data_In, base_s[WIDTH-1:1]};
      end
    end else begin
      shreg_r <= base_s;
    end
  end

  assign q = shreg_r;

endmodule

// File: rtl/serie_paralelo_receiver.sv
// serie_paralelo_receiver -- serial-to-parallel receiver with framing FSM.
//   Clk, Rst (async active-low) : clock and reset
//   bus (serie_paralelo_receiver_if.slave) : Data_In/Ena/Start/LeRi in,
//     Data_Out/Valid/Busy/Abort out (Parity_Err too with SERIE_PARITY_EN)
// Optional feature macro SERIE_PARITY_EN: an even-parity bit follows the
// WIDTH data bits and Parity_Err pulses alongside Valid on a mismatch.
// All outputs are registered; Valid and Abort are single-cycle pulses.
module serie_paralelo_receiver import serie_pkg::*; #(
  parameter int WIDTH = 4
) (
  input logic                    Clk,
  input logic                    Rst,
  serie_paralelo_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  serie_state_t     state_r, next_state_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             leri_r, leri_nxt_s;
  logic             shift_en_s, clear_s, dir_s;
  logic [WIDTH-1:0] shreg_s;
  logic             valid_nxt_s, abort_nxt_s, load_s;
  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] dout_r;
  logic             valid_r, abort_r, busy_r;
`ifdef SERIE_PARITY_EN
  logic             perr_nxt_s, perr_r;
`else
  logic [WIDTH-1:0] word_s;

  // Word including the bit being accepted now, so the last data bit can
  // complete the frame on its own edge.
  assign word_s = (leri_r == SERIE_MSB_FIRST) ? {shreg_s[WIDTH-2:0], bus.Data_In}
                                              : {bus.Data_In, shreg_s[WIDTH-1:1]};
`endif

  serie_shift_core #(.WIDTH(WIDTH)) u_core (
    .Clk      (Clk),
    .Rst      (Rst),
    .shift_en (shift_en_s),
    .clear    (clear_s),
    .dir      (dir_s),
    .Data_In  (bus.Data_In),
    .q        (shreg_s)
  );

  // Next-state, counter and output-pulse decode.
  always_comb begin
    next_state_s = state_r;
    count_nxt_s  = count_r;
    leri_nxt_s   = leri_r;
    shift_en_s   = 1'b0;
    clear_s      = 1'b0;
    dir_s        = leri_r;
    valid_nxt_s  = 1'b0;
    abort_nxt_s  = 1'b0;
    load_s       = 1'b0;
    load_val_s   = shreg_s;
`ifdef SERIE_PARITY_EN
    perr_nxt_s   = 1'b0;
`endif
    if (bus.Ena && bus.Start) begin
      // A start always begins a fresh frame; mid-frame it discards the partial word.
      next_state_s = ST_SHIFT;
      count_nxt_s  = CNT_W'(1);
      leri_nxt_s   = bus.LeRi;
      dir_s        = bus.LeRi;
      shift_en_s   = 1'b1;
      clear_s      = 1'b1;
      abort_nxt_s  = (state_r != ST_IDLE);
    end else if (bus.Ena) begin
      case (state_r)
        ST_SHIFT: begin
          shift_en_s  = 1'b1;
          count_nxt_s = count_r + CNT_W'(1);
          if (count_r == CNT_W'(WIDTH - 1)) begin
`ifdef SERIE_PARITY_EN
            next_state_s = ST_PARITY;
`else
            next_state_s = ST_IDLE;
            count_nxt_s  = {CNT_W{1'b0}};
            valid_nxt_s  = 1'b1;
            load_s       = 1'b1;
            load_val_s   = word_s;
`endif
          end else begin
            next_state_s = ST_SHIFT;
          end
        end
`ifdef SERIE_PARITY_EN
        ST_PARITY: begin
          // Parity bit is not shifted in; the register already holds the word.
          next_state_s = ST_IDLE;
          count_nxt_s  = {CNT_W{1'b0}};
          valid_nxt_s  = 1'b1;
          load_s       = 1'b1;
          load_val_s   = shreg_s;
          perr_nxt_s   = serie_parity_err(SERIE_WIDTH_MAX'(shreg_s), bus.Data_In);
        end
`endif
        default: begin
          // IDLE: a bit without Start is ignored.
          next_state_s = ST_IDLE;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
      leri_r  <= SERIE_LSB_FIRST;
      dout_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      abort_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef SERIE_PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else begin
      state_r <= next_state_s;
      count_r <= count_nxt_s;
      leri_r  <= leri_nxt_s;
      valid_r <= valid_nxt_s;
      abort_r <= abort_nxt_s;
      busy_r  <= (next_state_s != ST_IDLE);
      if (load_s) begin
        dout_r <= load_val_s;
      end else begin
        dout_r <= dout_r;
      end
`ifdef SERIE_PARITY_EN
      perr_r  <= perr_nxt_s;
`endif
    end
  end

  assign bus.Data_Out = dout_r;
  assign bus.Valid    = valid_r;
  assign bus.Abort    = abort_r;
  assign bus.Busy     = busy_r;
`ifdef SERIE_PARITY_EN
  assign bus.Parity_Err = perr_r;
`endif

endmodule

// File: doc/serie_paralelo_receiver.md
SERIE_PARALELO_RECEIVER -- requirements
Module: serie_paralelo_receiver

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word length in bits; legal range 2..16.
REQ-002 Clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-003 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Data_In  input  1  SHALL carry the serial data bit.
REQ-005 Ena  input  1  SHALL be the bit strobe; a bit is accepted only on a clock edge with Ena=1.
REQ-006 Start  input  1  SHALL mark the accepted bit as the first bit of a frame; it is qualified by Ena.
REQ-007 LeRi  input  1  SHALL select bit order: 1 = MSB first (shift left), 0 = LSB first (shift right).
REQ-008 Data_Out  output  WIDTH  SHALL hold the last completed word.
REQ-009 Valid  output  1  SHALL be a one-cycle pulse marking a new Data_Out.
REQ-010 Busy  output  1  SHALL be 1 while a frame is in progress.
REQ-011 Abort  output  1  SHALL be a one-cycle pulse when an in-progress frame is discarded.
REQ-012 Parity_Err  output  1  SHALL be present only when SERIE_PARITY_EN is defined (see REQ-026).

Function
REQ-013 FSM states SHALL be IDLE and SHIFT, plus PARITY when SERIE_PARITY_EN is defined.
REQ-014 In IDLE, when Ena=1 and Start=1: store Data_In as frame bit 1, set bit count to 1, latch LeRi for the frame, and go to SHIFT.
REQ-015 In IDLE, an accepted bit with Start=0 SHALL be ignored.
REQ-016 In SHIFT, on each edge with Ena=1 and Start=0: with LeRi=1, shift reg <= {reg[WIDTH-2:0], Data_In}; with LeRi=0, reg <= {Data_In, reg[WIDTH-1:1]}; increment the count.
REQ-017 When the WIDTH-th bit is accepted (no parity): on that same edge, Data_Out <= assembled word, Valid=1 for that cycle, and the FSM goes to IDLE.
REQ-018 Back-to-back frames SHALL be supported: a Start+Ena on the cycle right after completion begins a new frame with no gap.
REQ-019 Ena=0 SHALL hold all state; no timeout exists.
REQ-020 Start=1 with Ena=1 while in SHIFT or PARITY SHALL:
- pulse Abort for one cycle;
- discard the partial word;
- restart the frame as in REQ-014 using the current bit.
REQ-021 The LeRi value latched at Start SHALL govern the whole frame; changes to LeRi mid-frame SHALL be ignored.
REQ-022 Data_Out SHALL change only on a Valid cycle.
REQ-023 Busy SHALL be 1 in SHIFT and PARITY, and 0 in IDLE.
REQ-024 Valid and Abort SHALL never be 1 in the same cycle.

Reset
REQ-025 While Rst=0, regardless of Clk:
- FSM = IDLE, count = 0, shift register = 0;
- Data_Out = 0, Valid = 0, Busy = 0, Abort = 0, Parity_Err = 0.
An in-progress frame is lost, and no Valid or Abort is emitted when Rst is released.

Configuration
REQ-026 With SERIE_PARITY_EN defined, the frame SHALL be WIDTH data bits followed by one even-parity bit:
- after the WIDTH-th data bit the FSM enters PARITY;
- the next accepted bit completes the frame, and Valid pulses;
- Parity_Err pulses with Valid when the XOR of the data bits and the parity bit is 1;
- Data_Out SHALL update even when parity fails.
Without the macro, the PARITY state and Parity_Err port SHALL not exist, and the behaviour SHALL follow REQ-017.

Structure
REQ-027 Package serie_pkg SHALL hold:
- the FSM state typedef;
- the LeRi encoding constants SERIE_MSB_FIRST=1 and SERIE_LSB_FIRST=0;
- the WIDTH range limits.
REQ-028 The shift datapath SHALL be a sub-module serie_shift_core with ports Clk, Rst, shift enable, clear, direction and Data_In, and a WIDTH-bit parallel output. The FSM and counter SHALL live in the top module.

Verification
REQ-029 WIDTH=4, LeRi=1, bits 1,0,1,1 with Start on the first bit -> Data_Out=4'b1011, Valid 1 cycle, Busy low on the next cycle.
REQ-030 WIDTH=4, LeRi=0, bits 1,0,1,1 -> Data_Out=4'b1101.
REQ-031 Two frames back-to-back, 4'hA then 4'h5, with Ena continuously high -> Valid on cycles 4 and 8, with Data_Out 4'hA then 4'h5.
REQ-032 Start re-asserted on the 3rd bit, then 4 more bits 0,1,1,0 (MSB first) -> Abort pulse on the restart cycle, then Data_Out=4'b0110.
REQ-033 Rst pulsed low after 2 bits, then a full frame 4'h9 -> no Valid after the aborted frame, all outputs 0 during reset, then Data_Out=4'h9.
REQ-034 SERIE_PARITY_EN defined, data 4'b1011 with parity bit 0 -> Valid with Parity_Err=1; the same data with parity bit 1 -> Parity_Err=0.
